lcd_msg_arbiter: RTL and testbench

//   Shares the 16x2 character LCD between NREQ message sources. Each source

---
 rtl/lcd_msg_arbiter_pkg.sv | 25 ++
 rtl/lcd_msg_arbiter_rr_pick.sv | 43 ++++
 rtl/lcd_msg_arbiter.sv | 114 +++++++++++
 tb/tb_lcd_msg_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_msg_arbiter_pkg.sv
// Shared constants, FSM encoding and index helper for the LCD message arbiter.
package lcd_msg_arbiter_pkg;

    localparam int LCD_LINE_W = 128;

    // Sixteen ASCII spaces: what the panel shows when nothing is granted.
    localparam logic [LCD_LINE_W-1:0] BLANK_LINE = {16{8'h20}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_HOLD = 2'd2
    } arb_state_t;

    // (a + b) mod n for a, b < n <= 8, without a divider.
    function automatic logic [2:0] wrap_add(input logic [2:0] a, input logic [2:0] b, input int n);
        logic [3:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 4'(n)) begin
            s = s - 4'(n);
        end
        return s[2:0];
    endfunction

endpackage

// File: rtl/lcd_msg_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping modulo N.
module lcd_msg_arbiter_rr_pick
    import lcd_msg_arbiter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [2:0]   ptr,
    output logic [2:0]   idx,
    output logic         any
);

    logic [7:0]   req_pad;
    logic [N-1:0] rot;
    logic [2:0]   off;
    logic         found;

    assign req_pad = 8'(req);

    // Rotate so that bit 0 of rot is the request at position ptr.
    always_comb begin
        rot = '0;
        for (int i = 0; i < N; i++) begin
            rot[i] = req_pad[wrap_add(ptr, 3'(i), N)];
        end
    end

    // Priority-encode the rotated vector (lowest offset wins).
    always_comb begin
        off   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && rot[i]) begin
                off   = 3'(i);
                found = 1'b1;
            end
        end
    end

    assign idx = wrap_add(ptr, off, N);
    assign any = |req;

endmodule

// File: rtl/lcd_msg_arbiter.sv
// Shares one 16x2 LCD between NREQ message sources, round-robin, with a
// minimum dwell time per message. LINE1/LINE2 feed the LCD refresh driver.
//
// Handshake: a source raises req and holds req plus its message stable until
// it sees its ack bit pulse for one cycle; the message is sampled on the LOAD
// edge only, so req may drop once the grant is taken without losing the load.
module lcd_msg_arbiter
    import lcd_msg_arbiter_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int DWELL = 50_000_000,
    localparam int CW    = $clog2(DWELL + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*128-1:0]    msg_line1,
    input  logic [NREQ*128-1:0]    msg_line2,
    input  logic                   flush,
    output logic [NREQ-1:0]        ack,
    output logic [2:0]             grant_id,
    output logic                   busy,
    output logic [127:0]           LINE1,
    output logic [127:0]           LINE2,
    output logic [1:0]             state_dbg
);

    arb_state_t      state;
    logic [2:0]      ptr;
    logic [2:0]      sel;
    logic [CW-1:0]   cnt;
    logic [2:0]      pick_idx;
    logic            pick_any;
    logic [127:0]    sel_l1;
    logic [127:0]    sel_l2;

    lcd_msg_arbiter_rr_pick #(.N(NREQ)) u_pick (
        .req (req),
        .ptr (ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    // NREQ:1 message mux driven by the latched selection.
    always_comb begin
        sel_l1 = msg_line1[127:0];
        sel_l2 = msg_line2[127:0];
        for (int i = 0; i < NREQ; i++) begin
            if (sel == 3'(i)) begin
                sel_l1 = msg_line1[i*LCD_LINE_W +: LCD_LINE_W];
                sel_l2 = msg_line2[i*LCD_LINE_W +: LCD_LINE_W];
            end
        end
    end

    // Arbitration FSM, dwell counter and the registered LCD lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            ptr      <= '0;
            sel      <= '0;
            grant_id <= '0;
            ack      <= '0;
            busy     <= 1'b0;
            cnt      <= '0;
            LINE1    <= BLANK_LINE;
            LINE2    <= BLANK_LINE;
        end else begin
            ack <= '0;
            if (flush) begin
                // ptr and grant_id deliberately survive a flush.
                LINE1 <= BLANK_LINE;
                LINE2 <= BLANK_LINE;
                state <= S_IDLE;
                busy  <= 1'b0;
                cnt   <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (pick_any) begin
                            sel   <= pick_idx;
                            state <= S_LOAD;
                            busy  <= 1'b1;
                        end
                    end
                    S_LOAD: begin
                        LINE1    <= sel_l1;
                        LINE2    <= sel_l2;
                        ack      <= NREQ'(1) << sel;
                        grant_id <= sel;
                        ptr      <= wrap_add(sel, 3'd1, NREQ);
                        cnt      <= CW'(DWELL - 1);
                        state    <= S_HOLD;
                    end
                    S_HOLD: begin
                        if (cnt == '0) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_lcd_msg_arbiter.sv
// Self-checking bench for lcd_msg_arbiter (NREQ=4, DWELL=8).
module tb_lcd_msg_arbiter;
  import lcd_msg_arbiter_pkg::*;

  localparam int NREQ  = 4;
  localparam int DWELL = 8;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]   req   = '0;
  logic         flush = 1'b0;
  logic [127:0] tb_l1 [NREQ];
  logic [127:0] tb_l2 [NREQ];
  logic [511:0] msg_line1;
  logic [511:0] msg_line2;
  logic [3:0]   ack;
  logic [2:0]   grant_id;
  logic         busy;
  logic [127:0] LINE1;
  logic [127:0] LINE2;
  logic [1:0]   state_dbg;

  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign msg_line1[g*128 +: 128] = tb_l1[g];
    assign msg_line2[g*128 +: 128] = tb_l2[g];
  end

  lcd_msg_arbiter #(.NREQ(NREQ), .DWELL(DWELL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .msg_line1 (msg_line1),
    .msg_line2 (msg_line2),
    .flush     (flush),
    .ack       (ack),
    .grant_id  (grant_id),
    .busy      (busy),
    .LINE1     (LINE1),
    .LINE2     (LINE2),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [3:0] exp_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req   = '0;
    flush = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int cyc;
    cyc = 0;
    while (busy !== 1'b0 && cyc < 50) begin
      step();
      cyc++;
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: busy still %b after %0d cycles, required 0", name, busy, cyc);
    end
  endtask

  function automatic logic [127:0] line_of(input int src, input int which);
    if (src < 0) return BLANK_LINE;
    return (which == 1) ? tb_l1[src] : tb_l2[src];
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0] req;
    logic       flush;
    logic [3:0] ack;
    logic       busy;
    logic [2:0] grant;
    int         line_src;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [3:0] r, input logic f, input logic [3:0] a,
                     input logic b, input logic [2:0] g, input int ls);
    vec_t v;
    v.req = r; v.flush = f; v.ack = a; v.busy = b; v.grant = g; v.line_src = ls;
    tbl.push_back(v);
  endtask

  // ---------------- reference model (event-time view) ----------------
  int         m_edge;
  int         m_free_at;
  int         m_load_at;
  int         m_busy_end;
  int         m_sel;
  int         m_next;
  logic [2:0] m_grant;
  logic [3:0] m_ack;
  logic [127:0] m_l1, m_l2;

  task automatic model_reset();
    m_edge = 0; m_free_at = 0; m_load_at = -1; m_busy_end = 0;
    m_sel = 0; m_next = 0; m_grant = '0; m_ack = '0;
    m_l1 = BLANK_LINE; m_l2 = BLANK_LINE;
  endtask

  // Predicts outputs after the coming edge from the inputs presented to it.
  task automatic model_edge(input logic [3:0] r, input logic f);
    m_ack = '0;
    if (f) begin
      m_l1 = BLANK_LINE; m_l2 = BLANK_LINE;
      m_load_at = -1; m_busy_end = 0; m_free_at = m_edge + 1;
    end else if (m_edge == m_load_at) begin
      m_l1 = tb_l1[m_sel]; m_l2 = tb_l2[m_sel];
      m_ack = 4'(1 << m_sel);
      m_grant = 3'(m_sel);
      m_next = (m_sel + 1) % NREQ;
      m_load_at = -1;
      m_free_at = m_edge + DWELL + 1;
    end else if (m_edge >= m_free_at && r != 0) begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        if (r[(m_next + k) % NREQ]) m_sel = (m_next + k) % NREQ;
      end
      m_load_at = m_edge + 1;
      m_free_at = 32'h7fff_ffff;
      m_busy_end = m_edge + 1 + DWELL;
    end
    m_edge++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin
    int cyc, last, got, n_ack;

    for (int i = 0; i < NREQ; i++) begin
      tb_l1[i] = {"SRC", 8'(48 + i), " LINE1      "};
      tb_l2[i] = {"SRC", 8'(48 + i), " LINE2      "};
    end
    tb_l1[2] = "HELLO WORLD     ";
    tb_l2[2] = "FROM SOURCE 2   ";

    // Single request on source 2, then hold lockout for source 1.
    add(4'b0100, 0, 4'b0000, 1, 3'd0, -1);
    add(4'b0100, 0, 4'b0100, 1, 3'd2,  2);
    for (int i = 0; i < 7; i++) add(4'b0000, 0, 4'b0000, 1, 3'd2, 2);
    add(4'b0000, 0, 4'b0000, 0, 3'd2, 2);
    add(4'b0000, 0, 4'b0000, 0, 3'd2, 2);
    add(4'b0001, 0, 4'b0000, 1, 3'd2, 2);
    add(4'b0001, 0, 4'b0001, 1, 3'd0, 0);
    add(4'b0000, 0, 4'b0000, 1, 3'd0, 0);
    for (int i = 0; i < 6; i++) add(4'b0010, 0, 4'b0000, 1, 3'd0, 0);
    add(4'b0010, 0, 4'b0000, 0, 3'd0, 0);
    add(4'b0010, 0, 4'b0000, 1, 3'd0, 0);
    add(4'b0010, 0, 4'b0010, 1, 3'd1, 1);
    add(4'b0000, 0, 4'b0000, 1, 3'd1, 1);

    do_reset();
    chk("reset_line1", LINE1, BLANK_LINE);
    chk("reset_busy", 128'(busy), 128'(0));

    foreach (tbl[j]) begin
      req   = tbl[j].req;
      flush = tbl[j].flush;
      step();
      chk($sformatf("tbl%0d_ack", j),   128'(ack),      128'(tbl[j].ack));
      chk($sformatf("tbl%0d_busy", j),  128'(busy),     128'(tbl[j].busy));
      chk($sformatf("tbl%0d_grant", j), 128'(grant_id), 128'(tbl[j].grant));
      chk($sformatf("tbl%0d_line1", j), LINE1, line_of(tbl[j].line_src, 1));
      chk($sformatf("tbl%0d_line2", j), LINE2, line_of(tbl[j].line_src, 2));
    end
    req = '0;

    // Async reset in the middle of HOLD.
    #3 rst_n = 1'b0;
    #1;
    chk("rst_hold_line1", LINE1, BLANK_LINE);
    chk("rst_hold_line2", LINE2, BLANK_LINE);
    chk("rst_hold_ack",   128'(ack), 128'(0));
    chk("rst_hold_busy",  128'(busy), 128'(0));
    chk("rst_hold_grant", 128'(grant_id), 128'(0));
    chk("rst_hold_state", 128'(state_dbg), 128'(S_IDLE));
    step();
    rst_n = 1'b1;

    // Async reset in LOAD, held across the would-be ack edge.
    req = 4'b0001;
    step();
    chk("rst_load_pre_state", 128'(state_dbg), 128'(S_LOAD));
    #2 rst_n = 1'b0;
    step();
    chk("rst_load_ack",  128'(ack), 128'(0));
    chk("rst_load_busy", 128'(busy), 128'(0));
    chk("rst_load_line", LINE1, BLANK_LINE);
    req = '0;
    rst_n = 1'b1;
    step();

    // Round robin with every source requesting continuously.
    exp_q = {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    req = 4'b1111;
    cyc = 0; last = -1; got = 0;
    while (got < 5 && cyc < 200) begin
      step();
      cyc++;
      if (ack != 0) begin
        chk($sformatf("rr_order%0d", got), 128'(ack), 128'(exp_q.pop_front()));
        if (last >= 0) chk($sformatf("rr_spacing%0d", got), 128'(cyc - last), 128'(DWELL + 2));
        last = cyc;
        got++;
        if (got == 5) req = '0;
      end
    end
    n_tests++;
    if (got < 5) begin
      n_fail++;
      $display("FAIL rr_timeout: got %0d acks, required 5", got);
    end
    wait_idle("rr_idle");

    // Flush during the LOAD cycle for source 3.
    req = 4'b1000;
    step();
    chk("flush_pre_state", 128'(state_dbg), 128'(S_LOAD));
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_ack",   128'(ack), 128'(0));
    chk("flush_line1", LINE1, BLANK_LINE);
    chk("flush_line2", LINE2, BLANK_LINE);
    chk("flush_busy",  128'(busy), 128'(0));
    chk("flush_state", 128'(state_dbg), 128'(S_IDLE));
    chk("flush_grant", 128'(grant_id), 128'(0));
    step();
    step();
    chk("flush_regrant_ack",  128'(ack), 128'(4'b1000));
    chk("flush_regrant_line", LINE1, tb_l1[3]);
    req = '0;
    wait_idle("flush_idle");

    // Source 0 drops req during LOAD.
    req = 4'b0001;
    step();
    req = 4'b0000;
    step();
    chk("drop_ack",   128'(ack), 128'(4'b0001));
    chk("drop_line1", LINE1, tb_l1[0]);
    chk("drop_grant", 128'(grant_id), 128'(0));
    n_ack = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ack != 0) n_ack++;
    end
    chk("drop_single_ack", 128'(n_ack), 128'(0));

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 800; c++) begin
      model_edge(req, flush);
      step();
      chk("rand_ack",   128'(ack),      128'(m_ack));
      chk("rand_busy",  128'(busy),     128'(m_edge - 1 < m_busy_end));
      chk("rand_grant", 128'(grant_id), 128'(m_grant));
      chk("rand_line1", LINE1, m_l1);
      chk("rand_line2", LINE2, m_l2);
      flush = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && m_ack[i]) begin
          req[i] = 1'($urandom_range(0, 1));
        end else if (!req[i] && $urandom_range(0, 3) == 0) begin
          tb_l1[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
          tb_l2[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
          req[i] = 1'b1;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
